// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - AXI4-Lite response codes and shared read-master constants
package axi4_lite_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_EXOKAY = 2'b01;
    localparam axi_resp_t RESP_SLVERR = 2'b10;
    localparam axi_resp_t RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access
    localparam logic [2:0] ARPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - registered single-clock FIFO, no fall-through
module sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers (wrapping at DEPTH) and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // State registers; storage is cleared so the head reads zero out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/axi4_lite_read_master_pipelined.sv
// rtl/axi4_lite_read_master_pipelined.sv - credit-based AXI4-Lite read master with in-order response FIFO
module axi4_lite_read_master_pipelined
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_err,
    output logic                  err_sticky,
    input  logic                  err_clear,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_OUTSTANDING);

    logic [CW-1:0]         credits_q, credits_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic                  arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  err_sticky_q, err_sticky_d;

    logic                  cmd_hs, rsp_hs, ar_hs, r_hs;
    logic                  fifo_full, fifo_empty;
    logic [DATA_WIDTH+1:0] fifo_head;
    axi_resp_t             head_resp;

    // Credits are taken from registered state only, so rsp_ready never reaches cmd_ready
    assign cmd_ready = (credits_q < CREDIT_MAX) && (!arvalid_q || M_AXI_ARREADY);
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign ar_hs     = arvalid_q && M_AXI_ARREADY;
    assign r_hs      = M_AXI_RVALID && M_AXI_RREADY;
    assign rsp_valid = !fifo_empty;
    assign rsp_hs    = rsp_valid && rsp_ready;

    // A held credit guarantees a FIFO slot, so R acceptance only needs an issued AR
    assign M_AXI_RREADY  = (inflight_q != '0);
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = ARPROT_DEFAULT;

    assign head_resp  = fifo_head[1:0];
    assign rsp_data   = fifo_head[DATA_WIDTH+1:2];
    assign rsp_resp   = head_resp;
    assign rsp_err    = head_resp[1];
    assign err_sticky = err_sticky_q;
    assign busy       = (credits_q != '0);

    // Credit and in-flight counters, AR holding register and sticky error
    always_comb begin
        credits_d = credits_q;
        if (cmd_hs && !rsp_hs) begin
            credits_d = credits_q + 1'b1;
        end else if (!cmd_hs && rsp_hs) begin
            credits_d = credits_q - 1'b1;
        end

        inflight_d = inflight_q;
        if (ar_hs && !r_hs) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!ar_hs && r_hs) begin
            inflight_d = inflight_q - 1'b1;
        end

        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        if (cmd_hs) begin
            arvalid_d = 1'b1;
            araddr_d  = cmd_addr;
        end else if (ar_hs) begin
            arvalid_d = 1'b0;
        end

        // A clear loses against an error beat landing in the same cycle
        err_sticky_d = err_sticky_q;
        if (err_clear) begin
            err_sticky_d = 1'b0;
        end
        if (r_hs && M_AXI_RRESP[1]) begin
            err_sticky_d = 1'b1;
        end
    end

    // Control registers; reset discards everything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits_q    <= '0;
            inflight_q   <= '0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            credits_q    <= credits_d;
            inflight_q   <= inflight_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_hs),
        .push_data ({M_AXI_RDATA, M_AXI_RRESP}),
        .pop       (rsp_hs),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Credit reservation makes a push into a full FIFO impossible
    assert property (@(posedge clk) disable iff (!rst) !(r_hs && fifo_full));

endmodule
